ram16k_dma: RTL



---
 rtl/ram16k_dma.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram16k_dma.sv
// Single-channel block-copy / block-fill initiator driving a RAM16k port.
// All RAM-side outputs are registered; they are decoded from the next state.
module ram16k_dma #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_ld,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_C, WR, FIN} state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  L_ONE = LEN_W'(1);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d, count_q, count_d;
  logic [DATA_W-1:0]   fill_q, fill_d, data_q, data_d;
  logic                busy_q, busy_d, done_q, done_d, mem_ld_q, mem_ld_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_in_q, mem_in_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    count_d = count_q;
    fill_d  = fill_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: if (start) begin
        mode_d  = mode;
        src_d   = src_addr;
        dst_d   = dst_addr;
        rem_d   = len;
        fill_d  = fill_val;
        count_d = '0;
        if (len == '0) state_d = FIN;
        else           state_d = mode ? WR : RD_A;
      end
      RD_A: state_d = RD_C;
      RD_C: begin
        data_d  = mem_out;
        state_d = WR;
      end
      WR: begin
        count_d = count_q + L_ONE;
        dst_d   = dst_q + A_ONE;
        rem_d   = rem_q - L_ONE;
        if (!mode_q) src_d = src_q + A_ONE;
        if (rem_q == L_ONE) state_d = FIN;
        else                state_d = mode_q ? WR : RD_A;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs for the cycle we are about to enter, so the port is glitch-free.
    busy_d     = (state_d == RD_A) || (state_d == RD_C) || (state_d == WR);
    done_d     = (state_d == FIN);
    mem_ld_d   = (state_d == WR);
    mem_addr_d = '0;
    mem_in_d   = '0;
    if (state_d == RD_A || state_d == RD_C) begin
      mem_addr_d = src_d;
    end else if (state_d == WR) begin
      mem_addr_d = dst_d;
      mem_in_d   = mode_d ? fill_d : data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_ld_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_ld_q   <= mem_ld_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign mem_ld   = mem_ld_q;
  assign mem_addr = mem_addr_q;
  assign mem_in   = mem_in_q;

endmodule
